// File: rtl/pulp_power_domain_sequencer.sv
// Power-up/power-down sequencer for one switchable domain: orders switch enable,
// level-shifter clamps and domain reset so clamp and reset cover any unpowered period.
module pulp_power_domain_sequencer #(
  parameter int CLAMP_SETUP_CYCLES = 4,
  parameter int CLAMP_HOLD_CYCLES  = 4,
  parameter int RST_RELEASE_CYCLES = 8,
  parameter int TIMEOUT_CYCLES     = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pwr_req_i,
  output logic pwr_ack_o,
  output logic busy_o,
  output logic err_o,
  output logic switch_en_o,
  input  logic switch_ack_i,
  output logic clamp_o,
  output logic domain_rst_o
);

  localparam int MAX_SH  = (CLAMP_SETUP_CYCLES > CLAMP_HOLD_CYCLES) ? CLAMP_SETUP_CYCLES : CLAMP_HOLD_CYCLES;
  localparam int MAX_RT  = (RST_RELEASE_CYCLES > TIMEOUT_CYCLES) ? RST_RELEASE_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_CYC = (MAX_SH > MAX_RT) ? MAX_SH : MAX_RT;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] LD_SETUP   = CNT_W'(CLAMP_SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_HOLD    = CNT_W'(CLAMP_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_RST     = CNT_W'(RST_RELEASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_OFF     = 3'd0;
  localparam logic [2:0] ST_SW_ON   = 3'd1;
  localparam logic [2:0] ST_UNCLAMP = 3'd2;
  localparam logic [2:0] ST_RST_REL = 3'd3;
  localparam logic [2:0] ST_ON      = 3'd4;
  localparam logic [2:0] ST_CLAMP   = 3'd5;
  localparam logic [2:0] ST_SW_OFF  = 3'd6;
  localparam logic [2:0] ST_ERROR   = 3'd7;

  logic             ack_sync_p0;
  logic             ack_sync_p1;
  logic             ack_s;
  logic [2:0]       state_q;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_ld;
  logic             cnt_zero;

  // Switch ack synchronizer stage 0 -> stage 1
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_sync_p0 <= 1'b0;
      ack_sync_p1 <= 1'b0;
    end else begin
      ack_sync_p0 <= switch_ack_i;
      ack_sync_p1 <= ack_sync_p0;
    end
  end

  assign ack_s    = ack_sync_p1;
  assign cnt_zero = (cnt_q == '0);

  // Wait states give the ack priority over the timeout, so an ack seen in the last
  // allowed cycle still completes the sequence.
  always_comb begin
    state_nxt = state_q;
    cnt_ld    = '0;
    case (state_q)
      ST_OFF: begin
        if (pwr_req_i) begin
          state_nxt = ST_SW_ON;
          cnt_ld    = LD_TIMEOUT;
        end
      end
      ST_SW_ON: begin
        if (ack_s) begin
          state_nxt = ST_UNCLAMP;
          cnt_ld    = LD_HOLD;
        end else if (cnt_zero) begin
          state_nxt = ST_ERROR;
        end
      end
      ST_UNCLAMP: begin
        if (cnt_zero) begin
          state_nxt = ST_RST_REL;
          cnt_ld    = LD_RST;
        end
      end
      ST_RST_REL: begin
        if (cnt_zero) state_nxt = ST_ON;
      end
      ST_ON: begin
        if (!pwr_req_i) begin
          state_nxt = ST_CLAMP;
          cnt_ld    = LD_SETUP;
        end
      end
      ST_CLAMP: begin
        if (cnt_zero) begin
          state_nxt = ST_SW_OFF;
          cnt_ld    = LD_TIMEOUT;
        end
      end
      ST_SW_OFF: begin
        if (!ack_s) begin
          state_nxt = ST_OFF;
        end else if (cnt_zero) begin
          state_nxt = ST_ERROR;
        end
      end
      default: state_nxt = ST_ERROR;
    endcase
  end

  // Shared counter reloads on every state change and otherwise counts down to zero
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      if (state_nxt != state_q) begin
        cnt_q <= cnt_ld;
      end else if (!cnt_zero) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  always_comb begin
    switch_en_o  = 1'b0;
    clamp_o      = 1'b1;
    domain_rst_o = 1'b1;
    pwr_ack_o    = 1'b0;
    busy_o       = 1'b0;
    err_o        = 1'b0;
    case (state_q)
      ST_SW_ON, ST_UNCLAMP, ST_CLAMP: begin
        switch_en_o = 1'b1;
        busy_o      = 1'b1;
      end
      ST_RST_REL: begin
        switch_en_o = 1'b1;
        clamp_o     = 1'b0;
        busy_o      = 1'b1;
      end
      ST_ON: begin
        switch_en_o  = 1'b1;
        clamp_o      = 1'b0;
        domain_rst_o = 1'b0;
        pwr_ack_o    = 1'b1;
      end
      ST_SW_OFF: busy_o = 1'b1;
      ST_ERROR:  err_o  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pulp_power_domain_sequencer.sv
// Testbench for pulp_power_domain_sequencer: cycle-exact output timelines computed
// from the sequencing rules, with randomized switch-ack delays.
module tb_pulp_power_domain_sequencer;

  localparam int SETUP = 4;
  localparam int HOLD  = 4;
  localparam int RSTR  = 8;
  localparam int TMO   = 256;

  logic clk_i = 1'b0;
  logic rst_i;
  logic pwr_req_i;
  logic pwr_ack_o;
  logic busy_o;
  logic err_o;
  logic switch_en_o;
  logic switch_ack_i;
  logic clamp_o;
  logic domain_rst_o;

  int n_checks = 0;
  int n_fail   = 0;

  pulp_power_domain_sequencer #(
    .CLAMP_SETUP_CYCLES(SETUP),
    .CLAMP_HOLD_CYCLES (HOLD),
    .RST_RELEASE_CYCLES(RSTR),
    .TIMEOUT_CYCLES    (TMO)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .pwr_req_i   (pwr_req_i),
    .pwr_ack_o   (pwr_ack_o),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .switch_en_o (switch_en_o),
    .switch_ack_i(switch_ack_i),
    .clamp_o     (clamp_o),
    .domain_rst_o(domain_rst_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // Output vector order: {switch_en, clamp, domain_rst, pwr_ack, busy, err}
  localparam logic [5:0] V_RESET = 6'b011000;
  localparam logic [5:0] V_CLAMP = 6'b111010;
  localparam logic [5:0] V_WAIT_ON  = 6'b111010;
  localparam logic [5:0] V_WAIT_OFF = 6'b011010;
  localparam logic [5:0] V_ERROR = 6'b011001;

  function automatic logic [5:0] outs();
    return {switch_en_o, clamp_o, domain_rst_o, pwr_ack_o, busy_o, err_o};
  endfunction

  // Power-up from OFF, request seen at edge 0, raw ack high from cycle a onward.
  // Ack is usable two synchronizer cycles later and moves the sequence one cycle after that.
  function automatic logic [5:0] exp_up(input int k, input int a);
    int r, o;
    if (a + 2 > TMO) begin
      if (k <= TMO) return V_WAIT_ON;
      return V_ERROR;
    end
    r = a + 3 + HOLD;
    o = r + RSTR;
    return {1'b1, k < r, k < o, k >= o, k < o, 1'b0};
  endfunction

  // Power-down from ON, request drop seen at edge 0, raw ack low d cycles after en drops.
  function automatic logic [5:0] exp_down(input int k, input int d);
    int s, dd, off;
    s  = SETUP + 1;
    dd = s + d;
    if (dd + 2 > s + TMO - 1) begin
      if (k < s) return V_CLAMP;
      if (k < s + TMO) return V_WAIT_OFF;
      return V_ERROR;
    end
    off = dd + 3;
    return {k < s, 1'b1, 1'b1, 1'b0, k < off, 1'b0};
  endfunction

  task automatic test_reset();
    logic [5:0] got;
    rst_i        = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pwr_req_i    = 1'($urandom);
      switch_ack_i = 1'($urandom);
      @(posedge clk_i); #1;
      got = outs();
      n_checks++;
      if (got !== V_RESET) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: got %b expected %b", i, got, V_RESET);
      end
    end
    rst_i        = 1'b0;
    pwr_req_i    = 1'b0;
    switch_ack_i = 1'b0;
    @(posedge clk_i); #1;
    got = outs();
    n_checks++;
    if (got !== V_RESET) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected %b", got, V_RESET);
    end
  endtask

  // drop_at >= 0 withdraws the request mid-sequence; the final cycle checked is then
  // the first CLAMP cycle right after the single ON cycle.
  task automatic test_power_up(input int d, input int drop_at);
    int a, kmax;
    logic [5:0] got, exp;
    a = 1 + d;
    if (a + 2 > TMO) kmax = TMO + 4;
    else             kmax = a + 3 + HOLD + RSTR + 1;
    for (int k = 0; k <= kmax; k++) begin
      if (k > 0) begin
        got = outs();
        exp = exp_up(k, a);
        if (drop_at >= 0 && k == kmax) exp = V_CLAMP;
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL power_up d=%0d drop=%0d cycle %0d: got %b expected %b", d, drop_at, k, got, exp);
        end
      end
      pwr_req_i    = (drop_at >= 0 && k >= drop_at) ? 1'b0 : 1'b1;
      switch_ack_i = (k >= a);
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_power_down(input int d);
    int s, dd, kmax;
    logic [5:0] got, exp;
    s  = SETUP + 1;
    dd = s + d;
    if (dd + 2 > s + TMO - 1) kmax = s + TMO + 3;
    else                      kmax = dd + 4;
    for (int k = 0; k <= kmax; k++) begin
      if (k > 0) begin
        got = outs();
        exp = exp_down(k, d);
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL power_down d=%0d cycle %0d: got %b expected %b", d, k, got, exp);
        end
      end
      pwr_req_i    = 1'b0;
      switch_ack_i = (k < dd);
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_err_hold();
    logic [5:0] got;
    for (int i = 0; i < 12; i++) begin
      pwr_req_i    = 1'($urandom);
      switch_ack_i = 1'($urandom);
      @(posedge clk_i); #1;
      got = outs();
      n_checks++;
      if (got !== V_ERROR) begin
        n_fail++;
        $display("FAIL err_hold cycle %0d: got %b expected %b", i, got, V_ERROR);
      end
    end
  endtask

  // Reset pulsed in cycle 13, inside the reset-release window (cycles 11..18 for d=3)
  task automatic test_rst_mid();
    logic [5:0] got, exp;
    for (int k = 0; k <= 15; k++) begin
      if (k > 0) begin
        got = outs();
        exp = (k >= 14) ? V_RESET : exp_up(k, 4);
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL rst_mid cycle %0d: got %b expected %b", k, got, exp);
        end
      end
      rst_i        = (k == 13);
      pwr_req_i    = (k < 14);
      switch_ack_i = (k >= 4 && k < 14);
      @(posedge clk_i); #1;
    end
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i        = 1'b1;
    pwr_req_i    = 1'b0;
    switch_ack_i = 1'b0;

    test_reset();
    test_power_up(3, -1);
    test_power_down(3);

    test_power_up(TMO, -1);
    test_err_hold();
    test_reset();

    test_power_up(TMO - 3, -1);
    test_power_down(TMO - 3);
    test_power_up(TMO - 2, -1);
    test_reset();

    test_power_up(3, 3);
    test_reset();

    test_rst_mid();
    test_reset();

    for (int i = 0; i < 6; i++) begin
      test_power_up(int'($urandom_range(0, 10)), -1);
      test_power_down(int'($urandom_range(0, 10)));
    end

    test_power_up(2, -1);
    test_power_down(TMO);
    test_err_hold();
    test_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
